// File: rtl/serial_trigger_detector_pkg.sv
// Shared types and helpers for the serial trigger detector.
// Holds the FSM state encoding, hit-counter sizing and the masked compare
// used by every pattern slot.
package trojan_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ALARM = 2'd2
  } det_state_t;

  localparam int HIT_W = 8;
  localparam logic [HIT_W-1:0] HIT_MAX = 8'd255;

  // Widest frame supported; narrower frames are zero-extended before compare.
  localparam int MAX_LEN = 64;

  // A slot matches when it is enabled and every cared-about bit agrees.
  function automatic logic masked_match(input logic [MAX_LEN-1:0] frame,
                                        input logic [MAX_LEN-1:0] pat,
                                        input logic [MAX_LEN-1:0] mask,
                                        input logic               vld);
    return vld && (((frame ^ pat) & mask) == '0);
  endfunction

endpackage

// File: rtl/serial_trigger_detector_if.sv
// Bus bundle for the serial trigger detector: serial input, pattern table
// write port, clear, and the monitor outputs.
// Optional macro TRIGGER_LOG_EN adds the log_frame/log_idx capture outputs.
interface serial_trigger_detector_if
  import trojan_det_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter int NUM_PAT   = 4
);
  localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  logic                 in_valid;
  logic                 in_bit;
  logic                 frame_sync;
  logic                 pat_wr_en;
  logic [IDX_W-1:0]     pat_wr_idx;
  logic [FRAME_LEN-1:0] pat_wr_data;
  logic [FRAME_LEN-1:0] pat_wr_mask;
  logic                 pat_wr_vld;
  logic                 clear;
  logic                 frame_done;
  logic [NUM_PAT-1:0]   match_vec;
  logic [HIT_W-1:0]     hit_count;
  logic                 out;
`ifdef TRIGGER_LOG_EN
  logic [FRAME_LEN-1:0] log_frame;
  logic [IDX_W-1:0]     log_idx;

  modport master (
    output in_valid, in_bit, frame_sync, pat_wr_en, pat_wr_idx,
           pat_wr_data, pat_wr_mask, pat_wr_vld, clear,
    input  frame_done, match_vec, hit_count, out, log_frame, log_idx
  );

  modport slave (
    input  in_valid, in_bit, frame_sync, pat_wr_en, pat_wr_idx,
           pat_wr_data, pat_wr_mask, pat_wr_vld, clear,
    output frame_done, match_vec, hit_count, out, log_frame, log_idx
  );
`else
  modport master (
    output in_valid, in_bit, frame_sync, pat_wr_en, pat_wr_idx,
           pat_wr_data, pat_wr_mask, pat_wr_vld, clear,
    input  frame_done, match_vec, hit_count, out
  );

  modport slave (
    input  in_valid, in_bit, frame_sync, pat_wr_en, pat_wr_idx,
           pat_wr_data, pat_wr_mask, pat_wr_vld, clear,
    output frame_done, match_vec, hit_count, out
  );
`endif

endinterface

// File: rtl/serial_trigger_detector_shifter.sv
// Frame assembler: shifts qualified bits MSB-first and flags the cycle in
// which the last bit of a frame arrives. frame_word already contains that
// incoming bit so the comparison can happen on the same edge.
module frame_shifter #(
  parameter int FRAME_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 frame_sync,
  output logic [FRAME_LEN-1:0] frame_word,
  output logic                 frame_last
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] sreg;
  logic [CNT_W-1:0]     bcnt;

  assign frame_word = {sreg[FRAME_LEN-2:0], in_bit};
  assign frame_last = in_valid && !frame_sync && (bcnt == LAST_BIT);

  // Shift qualified bits; frame_sync drops the partial frame and its bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      bcnt <= '0;
    end else if (frame_sync) begin
      bcnt <= '0;
    end else if (in_valid) begin
      sreg <= frame_word;
      bcnt <= frame_last ? '0 : bcnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_trigger_detector.sv
// Serial trigger detector top: pattern table, per-slot masked compare,
// consecutive-hit counter, alarm FSM and optional trigger log.
// Optional macro TRIGGER_LOG_EN adds log_frame/log_idx, which record the
// frame that raised the alarm and its lowest matching slot.
module serial_trigger_detector
  import trojan_det_pkg::*;
#(
  parameter int FRAME_LEN    = 32,
  parameter int NUM_PAT      = 4,
  parameter int MATCH_THRESH = 3
) (
  input logic                     clk,
  input logic                     reset,
  serial_trigger_detector_if.slave bus
);
  localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam logic [HIT_W-1:0] THRESH = HIT_W'(MATCH_THRESH);

  logic [FRAME_LEN-1:0] frame_word;
  logic                 frame_last;

  logic [FRAME_LEN-1:0] pat_tbl  [NUM_PAT];
  logic [FRAME_LEN-1:0] mask_tbl [NUM_PAT];
  logic [NUM_PAT-1:0]   vld_tbl;

  logic [NUM_PAT-1:0]   match_now;
  logic                 any_match;
  logic [HIT_W-1:0]     next_hit;
  logic                 alarm_set;

  logic                 frame_done_q;
  logic [NUM_PAT-1:0]   match_vec_q;
  logic [HIT_W-1:0]     hit_q;
  logic                 out_q;
  det_state_t           state;

  frame_shifter #(.FRAME_LEN(FRAME_LEN)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .in_bit     (bus.in_bit),
    .frame_sync (bus.frame_sync),
    .frame_word (frame_word),
    .frame_last (frame_last)
  );

  // Pattern table writes land at the edge, so a same-cycle compare sees old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        pat_tbl[k]  <= '0;
        mask_tbl[k] <= '0;
      end
      vld_tbl <= '0;
    end else if (bus.pat_wr_en && (int'(bus.pat_wr_idx) < NUM_PAT)) begin
      pat_tbl[bus.pat_wr_idx]  <= bus.pat_wr_data;
      mask_tbl[bus.pat_wr_idx] <= bus.pat_wr_mask;
      vld_tbl[bus.pat_wr_idx]  <= bus.pat_wr_vld;
    end
  end

  // Compare the assembling word against every slot.
  always_comb begin
    match_now = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      match_now[k] = masked_match(MAX_LEN'(frame_word), MAX_LEN'(pat_tbl[k]),
                                  MAX_LEN'(mask_tbl[k]), vld_tbl[k]);
    end
  end

  assign any_match = |match_now;

  // Hit count a completion would produce: saturating increment or restart.
  always_comb begin
    next_hit = '0;
    if (any_match) begin
      next_hit = (hit_q == HIT_MAX) ? HIT_MAX : hit_q + 1'b1;
    end
  end

  assign alarm_set = frame_last && (next_hit >= THRESH);

  // Per-frame result registers; clear zeroes the counter even on a completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done_q <= 1'b0;
      match_vec_q  <= '0;
      hit_q        <= '0;
    end else begin
      frame_done_q <= frame_last;
      if (frame_last) begin
        match_vec_q <= match_now;
      end
      if (bus.clear) begin
        hit_q <= '0;
      end else if (frame_last) begin
        hit_q <= next_hit;
      end
    end
  end

  // Alarm FSM with registered sticky output; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      out_q <= 1'b0;
    end else begin
      if (alarm_set) begin
        state <= ALARM;
        out_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_valid) begin
              state <= SHIFT;
            end
          end
          SHIFT: begin
            state <= SHIFT;
          end
          ALARM: begin
            if (bus.clear) begin
              state <= SHIFT;
              out_q <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            out_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.frame_done = frame_done_q;
  assign bus.match_vec  = match_vec_q;
  assign bus.hit_count  = hit_q;
  assign bus.out        = out_q;

`ifdef TRIGGER_LOG_EN
  logic [IDX_W-1:0]     first_idx;
  logic [FRAME_LEN-1:0] log_frame_q;
  logic [IDX_W-1:0]     log_idx_q;

  // Lowest-numbered matching slot for the word being completed.
  always_comb begin
    first_idx = '0;
    for (int k = NUM_PAT - 1; k >= 0; k--) begin
      if (match_now[k]) begin
        first_idx = IDX_W'(k);
      end
    end
  end

  // Capture only the completion that raises the alarm; frozen while it stays up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      log_frame_q <= '0;
      log_idx_q   <= '0;
    end else if (alarm_set && !out_q) begin
      log_frame_q <= frame_word;
      log_idx_q   <= first_idx;
    end
  end

  assign bus.log_frame = log_frame_q;
  assign bus.log_idx   = log_idx_q;
`endif

endmodule

// File: doc/serial_trigger_detector.md
# serial_trigger_detector

Parametrised serial frame monitor for the hardware-trojan study. It deserialises a gated bit stream into fixed-length frames and compares each completed frame against a programmable table of masked trigger patterns. It counts consecutive matching frames and raises a sticky alarm once a threshold is reached. It sits on the serial input path, alongside the payload logic it guards, and generalises the fixed single-output trojan model in frame length, pattern count and trigger depth.

## Interface
- FRAME_LEN, 32, bits per frame; 2..64
- NUM_PAT, 4, number of trigger pattern slots; 1..16
- MATCH_THRESH, 3, consecutive matching frames needed to alarm; 1..255
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- in_valid  input  1  qualifies in_bit; bits are ignored when low
- in_bit  input  1  serial data, MSB of frame first
- frame_sync  input  1  synchronous restart; discards the partial frame and the bit counter returns to 0
- pat_wr_en  input  1  pattern table write strobe
- pat_wr_idx  input  $clog2(NUM_PAT) (min 1)  slot to write
- pat_wr_data  input  FRAME_LEN  pattern value
- pat_wr_mask  input  FRAME_LEN  1 = compare this bit, 0 = don't care
- pat_wr_vld  input  1  slot enable written with the pattern
- clear  input  1  clears alarm and hit counter
- frame_done  output  1  one-cycle pulse per completed frame
- match_vec  output  NUM_PAT  per-slot match for the last completed frame
- hit_count  output  8  current consecutive-match count, saturating
- out  output  1  sticky alarm

## Operation
- Shift register sreg[FRAME_LEN-1:0] captures bits as sreg <= {sreg[FRAME_LEN-2:0], in_bit} on in_valid. The bit counter bcnt runs 0..FRAME_LEN-1.
- Frame completes on the edge where in_valid=1 and bcnt=FRAME_LEN-1. The compared word is {sreg[FRAME_LEN-2:0], in_bit}, which includes the current bit. bcnt then wraps to 0.
- Slot k matches when vld[k] and ((frame ^ pat[k]) & mask[k]) == 0. A valid slot with mask all-zero matches every frame.
- On completion, match_vec and frame_done are registered from the comparison.
  - Any match: hit_count increments, saturating at 255.
  - No match: hit_count returns to 0.
- out sets when the post-update hit_count is at least MATCH_THRESH. It holds until clear or reset.
- FSM states:
  - IDLE: after reset, until the first in_valid.
  - SHIFT: frame assembly.
  - ALARM: out=1. Shifting and comparison continue; hit_count keeps tracking.
  - Transitions: clear in ALARM goes to SHIFT. Leaving ALARM never discards a partial frame.
- frame_sync wins over in_valid in the same cycle. The bit is discarded, bcnt becomes 0, and hit_count is kept.
- A pattern write in the same cycle as a frame completion: the comparison uses the old slot contents, and the write takes effect next cycle.
- clear in the same cycle as an alarm-setting completion: set wins, and out stays 1. hit_count is still zeroed by clear.
- Reset mid-frame: partial frame lost. All slots become invalid, with pattern and mask = 0.

## Timing
- Reset values: frame_done=0, match_vec=0, hit_count=0, out=0. FSM=IDLE, bcnt=0, sreg=0.
- Latency:
  - frame_done, match_vec and hit_count update on the edge that samples the last bit; visible the following cycle.
  - out rises on that same edge.
- frame_done is exactly one cycle wide. match_vec holds until the next completion.
- Back-to-back frames are supported with no gap; throughput is 1 bit/cycle.
- Write-to-use latency for the pattern table is 1 cycle.

## Configuration
- TRIGGER_LOG_EN defined adds two outputs:
  - log_frame[FRAME_LEN-1:0]: captures the frame that set out.
  - log_idx[$clog2(NUM_PAT)-1:0]: lowest matching slot index for that frame.
  - Both reset to 0, are frozen while out=1, and are re-armed by clear.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Package trojan_det_pkg holds:
  - FSM state enum: IDLE, SHIFT, ALARM.
  - HIT_W=8 and HIT_MAX=255 constants.
  - A function for masked compare.
- Sub-module frame_shifter holds sreg and bcnt, handles frame_sync, and emits frame_word plus a frame_last strobe.
- The top level holds the pattern table, comparison, counter, FSM and log.

## Test plan
- Defaults; slot 0 = 32'hA5A5_A5A5 with full mask and vld=1; three consecutive frames of A5A5A5A5 -> frame_done after bits 32/64/96, hit_count 1,2,3, out=1 on the third completion.
- Same setup; frames A5A5A5A5, 00000000, A5A5A5A5 -> hit_count 1,0,1 and out stays 0.
- Slot 2 = 32'hFFFF_0000 with mask 32'hFFFF_0000; frame FFFF_1234 -> match_vec=4'b0100. Frame FFFE_0000 -> match_vec=0.
- in_valid toggled low for random cycles within a frame -> identical results to the gap-free run; frame_sync at bit 17 -> the next 32 valid bits form the frame.
- In ALARM, assert clear on the same cycle as a matching completion with MATCH_THRESH=1 -> out stays 1 and hit_count=0; a later clear with no completion -> out=0.
- Reset low mid-frame at bit 10 -> all outputs 0 and slots invalid; after release, a frame of any value gives match_vec=0. With TRIGGER_LOG_EN, the alarm-setting frame appears on log_frame and is unchanged by later frames.
